// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM states, requester ids and access-size codes.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

endpackage

// File: rtl/ram_arbiter_load_extend.sv
// Sign/zero-extends raw RAM read data to 32 bits by access size; purely combinational.
// Size 2'b10 is illegal: flagged, and the value is forced to zero.
module load_extend
    import ram_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] raw,
    output logic [31:0] value,
    output logic        illegal
);

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (size)
            SIZE_BYTE: value = {{24{~zero_ext & raw[7]}}, raw[7:0]};
            SIZE_HALF: value = {{16{~zero_ext & raw[15]}}, raw[15:0]};
            SIZE_WORD: value = raw;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates fetch and load/store ports onto the two-phase RAM; 3 cycles from grant to ready.
// Requesters hold req until their one-cycle ready; ties go to the port not served last.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [31:0]           if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic                  ls_unsigned,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_ready,
    output logic [31:0]           ls_rdata,
    output logic                  ls_err,
    output logic                  busy,
    output logic                  mem_write_address,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_data_size,
    output logic [31:0]           mem_data_out,
    output logic                  mem_data_oe,
    input  logic [31:0]           mem_data_in
);

    state_t                state;
    port_t                 port;
    port_t                 last_port;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_wdata;

    logic                  grant;
    logic                  grant_ls;
    logic [31:0]           ext_data;
    logic                  ext_illegal;

    load_extend u_load_extend (
        .size     (req_size),
        .zero_ext (req_unsigned),
        .raw      (mem_data_in),
        .value    (ext_data),
        .illegal  (ext_illegal)
    );

    // In RESP only the port that was not just served may be granted.
    always_comb begin
        grant    = 1'b0;
        grant_ls = 1'b0;
        case (state)
            IDLE: begin
                grant    = ls_req | if_req;
                grant_ls = ls_req & (~if_req | (last_port == PORT_IF));
            end
            RESP: begin
                if (port == PORT_IF) begin
                    grant    = ls_req;
                    grant_ls = 1'b1;
                end else begin
                    grant    = if_req;
                    grant_ls = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            port              <= PORT_IF;
            last_port         <= PORT_IF;
            req_addr          <= '0;
            req_we            <= 1'b0;
            req_size          <= '0;
            req_unsigned      <= 1'b0;
            req_wdata         <= '0;
            if_rdata          <= '0;
            ls_rdata          <= '0;
            if_ready          <= 1'b0;
            ls_ready          <= 1'b0;
            ls_err            <= 1'b0;
            busy              <= 1'b0;
            mem_write_address <= 1'b0;
            mem_address       <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_data_size     <= '0;
            mem_data_out      <= '0;
            mem_data_oe       <= 1'b0;
        end else begin
            mem_write_address <= 1'b0;
            mem_address       <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_data_size     <= '0;
            mem_data_out      <= '0;
            mem_data_oe       <= 1'b0;
            if_ready          <= 1'b0;
            ls_ready          <= 1'b0;
            ls_err            <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (grant) begin
                        state             <= ADDR;
                        busy              <= 1'b1;
                        port              <= grant_ls ? PORT_LS : PORT_IF;
                        last_port         <= grant_ls ? PORT_LS : PORT_IF;
                        req_addr          <= grant_ls ? ls_addr : if_addr;
                        req_we            <= grant_ls & ls_we;
                        req_size          <= grant_ls ? ls_size : SIZE_WORD;
                        req_unsigned      <= grant_ls & ls_unsigned;
                        req_wdata         <= grant_ls ? ls_wdata : 32'h0;
                        mem_write_address <= 1'b1;
                        mem_address       <= grant_ls ? ls_addr : if_addr;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ADDR: begin
                    state         <= ACCESS;
                    mem_data_size <= req_size;
                    if (req_we) begin
                        mem_write    <= ~ext_illegal;
                        mem_data_oe  <= ~ext_illegal;
                        mem_data_out <= req_wdata;
                    end else begin
                        mem_read <= 1'b1;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (port == PORT_LS) begin
                        ls_ready <= 1'b1;
                        ls_err   <= ext_illegal;
                        if (!req_we) ls_rdata <= ext_data;
                    end else begin
                        if_ready <= 1'b1;
                        if_rdata <= ext_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
